// File: rtl/mem_stage_pkg.sv
// Shared widths, side-band bit positions and load_op encoding for the memory stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 198;
    localparam int MS_TO_WS_BUS_WD = 192;
    localparam int SIDE_WD         = 122;
    localparam int SIDE_LSB        = 70;
    localparam int MS_FORWARD_WD   = 40;

    // Side-band flags are indexed in bus coordinates, i.e. es_to_ms_bus[SIDE_EX].
    localparam int SIDE_CSR_RE = 79;
    localparam int SIDE_EX     = 80;
    localparam int SIDE_ERTN   = 88;

    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    typedef struct packed {
        logic               ms_req;
        logic [4:0]         load_op;
        logic [SIDE_WD-1:0] side;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        alu_result;
        logic [31:0]        pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [SIDE_WD-1:0] side;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        final_result;
        logic [31:0]        pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, bus, data-SRAM response and flush signals around the memory stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       back_flush;
    logic                       ms_ex_flag;
    logic [MS_FORWARD_WD-1:0]   ms_forward;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, back_flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_flag, ms_forward
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, back_flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_flag, ms_forward
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a 32-bit SRAM word and sign/zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  load_op,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = raw >> {addr_lo, 3'b000};

    always_comb begin
        load_data = raw;
        if (load_op[LD_B])
            load_data = {{24{shifted[7]}}, shifted[7:0]};
        else if (load_op[LD_BU])
            load_data = {24'b0, shifted[7:0]};
        else if (load_op[LD_H])
            load_data = {{16{shifted[15]}}, shifted[15:0]};
        else if (load_op[LD_HU])
            load_data = {16'b0, shifted[15:0]};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data-SRAM response, buffers it while ws stalls,
// and drops responses orphaned by a ws flush.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
    es_to_ms_t                  ms_bus;
    logic                       buf_valid;
    logic [31:0]                buf_data;
    logic [1:0]                 discard_cnt;

    logic        own_ok;
    logic        ms_ready_go;
    logic        is_load;
    logic        rf_we;
    logic        res_pending;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] raw_data;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_bus  = es_to_ms_bus_r;
    assign is_load = |ms_bus.load_op;

    // Responses come back in order, so older orphaned ones are swallowed before ours.
    assign own_ok      = bus.data_sram_data_ok & (discard_cnt == 2'd0);
    assign ms_ready_go = !ms_bus.ms_req | buf_valid | own_ok;

    assign bus.ms_allowin     = !ms_valid | (ms_ready_go & bus.ws_allowin);
    assign bus.ms_to_ws_valid = ms_valid & ms_ready_go;
    assign bus.ms_ex_flag     = ms_valid & (es_to_ms_bus_r[SIDE_EX] | es_to_ms_bus_r[SIDE_ERTN]);

    assign raw_data = buf_valid ? buf_data : bus.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .raw       (raw_data),
        .addr_lo   (ms_bus.alu_result[1:0]),
        .load_op   (ms_bus.load_op),
        .load_data (load_data)
    );

    assign final_result = is_load ? load_data : ms_bus.alu_result;

    assign bus.ms_to_ws_bus = {ms_bus.side, ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};

    assign rf_we       = ms_bus.gr_we & ms_valid & !es_to_ms_bus_r[SIDE_EX];
    assign res_pending = ms_valid & is_load & !buf_valid & !own_ok;

    assign bus.ms_forward = {res_pending, es_to_ms_bus_r[SIDE_CSR_RE], rf_we, ms_bus.dest, final_result};

    always_ff @(posedge clk) begin
        if (reset)
            ms_valid <= 1'b0;
        else if (bus.back_flush)
            ms_valid <= 1'b0;
        else if (bus.ms_allowin)
            ms_valid <= bus.es_to_ms_valid;
    end

    always_ff @(posedge clk) begin
        if (bus.es_to_ms_valid && bus.ms_allowin)
            es_to_ms_bus_r <= bus.es_to_ms_bus;
    end

    // Hold our response while ws is stalled, since rdata is only valid with data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'b0;
        end else if (bus.back_flush || (bus.ws_allowin && ms_ready_go)) begin
            buf_valid <= 1'b0;
        end else if (own_ok && ms_valid && ms_bus.ms_req && !buf_valid && !bus.ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= bus.data_sram_rdata;
        end
    end

    assign cnt_inc = bus.back_flush & ms_valid & ms_bus.ms_req & !buf_valid & !own_ok;
    assign cnt_dec = bus.data_sram_data_ok & (discard_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else if (cnt_inc && !cnt_dec) begin
            if (discard_cnt != 2'd3)
                discard_cnt <= discard_cnt + 2'd1;
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

endmodule
